// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle execute controller between decode and the ALU.
// Accepts one decoded operation over a valid/ready handshake. It drives the
// registered operand-select code and ALU opcode, captures the ALU result, and
// presents that result downstream over a second valid/ready handshake.
// Optional feature macro: EXEC_SERIAL_SHIFT_EN. When it is defined, shifts
// with a nonzero amount are done one bit per cycle in the SHIFT state, so the
// ALU needs no barrel shifter. When it is undefined, every operation goes
// through EXEC and the ALU.
module exec_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [3:0]  in_aluop,
  input  logic        in_is_shift,
  input  logic [1:0]  in_shift_type,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs1,
  output logic [2:0]  alu_src,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_q, res_d;

`ifdef EXEC_SERIAL_SHIFT_EN
  logic [1:0]  type_q, type_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] shifted;
`else
  logic        unused_shift_inputs;
  assign unused_shift_inputs = ^{in_is_shift, in_shift_type, in_shamt, in_rs1};
`endif

  // Handshake and status outputs decode directly from the registered state.
  assign in_ready   = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign alu_src    = sel_q;
  assign alu_op     = op_q;

`ifdef EXEC_SERIAL_SHIFT_EN
  // One-bit step of the serial shifter; type 3 behaves as a logical right shift.
  always_comb begin
    shifted = {1'b0, acc_q[31:1]};
    case (type_q)
      2'd0:    shifted = {acc_q[30:0], 1'b0};
      2'd2:    shifted = {acc_q[31], acc_q[31:1]};
      default: shifted = {1'b0, acc_q[31:1]};
    endcase
  end
`endif

  // Next-state logic. A flush overrides everything and returns the FSM to IDLE
  // while keeping the last result and the operand/opcode selects.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    res_d   = res_q;
`ifdef EXEC_SERIAL_SHIFT_EN
    type_d  = type_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sel_d = in_sel;
          op_d  = in_aluop;
`ifdef EXEC_SERIAL_SHIFT_EN
          type_d = in_shift_type;
          cnt_d  = in_shamt;
          acc_d  = in_rs1;
          if (in_is_shift && (in_shamt != 5'd0)) begin
            state_d = SHIFT;
          end else begin
            state_d = EXEC;
          end
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        res_d   = alu_result;
        state_d = DONE;
      end
`ifdef EXEC_SERIAL_SHIFT_EN
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          res_d   = shifted;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
`ifdef EXEC_SERIAL_SHIFT_EN
      cnt_d   = cnt_q;
      acc_d   = acc_q;
`endif
    end
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      op_q    <= 4'd0;
      res_q   <= 32'd0;
`ifdef EXEC_SERIAL_SHIFT_EN
      type_q  <= 2'd0;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifdef EXEC_SERIAL_SHIFT_EN
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer. The shift-mode checks follow
// EXEC_SERIAL_SHIFT_EN in the same way the design does.
module tb_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [3:0]  in_aluop;
  logic        in_is_shift;
  logic [1:0]  in_shift_type;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs1;
  logic [2:0]  alu_src;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks;
  int failures;

  exec_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .in_aluop      (in_aluop),
    .in_is_shift   (in_is_shift),
    .in_shift_type (in_shift_type),
    .in_shamt      (in_shamt),
    .in_rs1        (in_rs1),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .busy          (busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] sel,
                               input logic [3:0] aluop, input logic is_shift,
                               input logic [1:0] stype, input logic [4:0] shamt,
                               input logic [31:0] rs1);
    in_valid      = valid;
    in_sel        = sel;
    in_aluop      = aluop;
    in_is_shift   = is_shift;
    in_shift_type = stype;
    in_shamt      = shamt;
    in_rs1        = rs1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    checkOutput({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    checkOutput({tag, "_busy"},       {31'd0, busy},       32'd0);
    checkOutput({tag, "_out_result"}, out_result,          32'd0);
    checkOutput({tag, "_alu_src"},    {29'd0, alu_src},    32'd0);
    checkOutput({tag, "_alu_op"},     {28'd0, alu_op},     32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    alu_result = 32'd0;
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0, 2'd0, 5'd0, 32'd0);

    // Reset state
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD, sel 0: EXEC at T+1, out_valid for exactly one cycle at T+2
    applyStimulus(1'b1, 3'd0, 4'h0, 1'b0, 2'd0, 5'd0, 32'd0);
    alu_result = 32'h0000_0007;
    tick();
    in_valid = 1'b0;
    checkOutput("add_exec_busy",     {31'd0, busy},      32'd1);
    checkOutput("add_exec_alu_src",  {29'd0, alu_src},   32'd0);
    checkOutput("add_exec_out_valid",{31'd0, out_valid}, 32'd0);
    checkOutput("add_exec_in_ready", {31'd0, in_ready},  32'd0);
    tick();
    checkOutput("add_done_out_valid",{31'd0, out_valid}, 32'd1);
    checkOutput("add_done_result",   out_result,         32'h0000_0007);
    tick();
    checkOutput("add_idle_out_valid",{31'd0, out_valid}, 32'd0);
    checkOutput("add_idle_busy",     {31'd0, busy},      32'd0);
    checkOutput("add_idle_in_ready", {31'd0, in_ready},  32'd1);

    // Backpressure: five cycles in DONE with out_ready low
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd3, 4'h5, 1'b0, 2'd0, 5'd0, 32'd0);
    alu_result = 32'hCAFE_BABE;
    tick();
    checkOutput("bp_exec_alu_src", {29'd0, alu_src}, 32'd3);
    checkOutput("bp_exec_alu_op",  {28'd0, alu_op},  32'd5);
    applyStimulus(1'b1, 3'd6, 4'h9, 1'b0, 2'd0, 5'd0, 32'd0);
    tick();
    alu_result = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_out_result", out_result,        32'hCAFE_BABE);
      checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    checkOutput("bp_release_busy",    {31'd0, busy},      32'd0);
    checkOutput("bp_release_valid",   {31'd0, out_valid}, 32'd0);
    checkOutput("bp_ignored_alu_src", {29'd0, alu_src},   32'd3);
    checkOutput("bp_ignored_alu_op",  {28'd0, alu_op},    32'd5);

    // flush together with in_valid in IDLE: nothing accepted
    flush = 1'b1;
    applyStimulus(1'b1, 3'd2, 4'h7, 1'b0, 2'd0, 5'd0, 32'd0);
    #1;
    checkOutput("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("flush_idle_busy",    {31'd0, busy},    32'd0);
    checkOutput("flush_idle_alu_src", {29'd0, alu_src}, 32'd3);
    flush    = 1'b0;
    in_valid = 1'b0;

    // flush during EXEC: back to IDLE, result and selects kept
    applyStimulus(1'b1, 3'd4, 4'h2, 1'b0, 2'd0, 5'd0, 32'd0);
    alu_result = 32'h0000_0055;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    checkOutput("flush_exec_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_exec_busy",      {31'd0, busy},      32'd0);
    checkOutput("flush_exec_result",    out_result,         32'hCAFE_BABE);
    checkOutput("flush_exec_alu_src",   {29'd0, alu_src},   32'd4);
    flush = 1'b0;
    #1;
    checkOutput("flush_exec_in_ready",  {31'd0, in_ready},  32'd1);
    tick();

    // Asynchronous reset while in DONE
    applyStimulus(1'b1, 3'd1, 4'h3, 1'b0, 2'd0, 5'd0, 32'd0);
    alu_result = 32'h0000_A5A5;
    out_ready  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("arst_pre_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("arst_pre_result",    out_result,         32'h0000_A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("arst");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

`ifdef EXEC_SERIAL_SHIFT_EN
    // Serial SRA of 0x8000_0000 by 4: out_valid at T+5, alu_result ignored
    applyStimulus(1'b1, 3'd5, 4'hD, 1'b1, 2'd2, 5'd4, 32'h8000_0000);
    alu_result = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("sra_wait_out_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    checkOutput("sra_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sra_result",    out_result,         32'hF800_0000);
    tick();

    // Serial SLL of 1 by 31: out_valid at T+32
    applyStimulus(1'b1, 3'd5, 4'hC, 1'b1, 2'd0, 5'd31, 32'h0000_0001);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput("sll_wait_out_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    checkOutput("sll_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sll_result",    out_result,         32'h8000_0000);
    tick();

    // shamt 0 shift goes through EXEC and takes the ALU result
    applyStimulus(1'b1, 3'd5, 4'hC, 1'b1, 2'd1, 5'd0, 32'h0000_00F0);
    alu_result = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("shamt0_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("shamt0_result",    out_result,         32'h0000_1234);
    tick();

    // Flush during SHIFT (shamt 10), flush raised in cycle T+4
    applyStimulus(1'b1, 3'd5, 4'hD, 1'b1, 2'd1, 5'd10, 32'hFFFF_0000);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("flush_shift_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    checkOutput("flush_shift_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_shift_busy",      {31'd0, busy},      32'd0);
    checkOutput("flush_shift_result",    out_result,         32'h0000_1234);
    flush = 1'b0;
    #1;
    checkOutput("flush_shift_in_ready",  {31'd0, in_ready},  32'd1);
    tick();
`else
    // Without serial shifting, SRL by 3 uses the ALU result, out_valid at T+2
    applyStimulus(1'b1, 3'd5, 4'hD, 1'b1, 2'd1, 5'd3, 32'h0000_00F0);
    alu_result = 32'h0000_001E;
    tick();
    in_valid = 1'b0;
    checkOutput("srl_exec_busy",      {31'd0, busy},      32'd1);
    checkOutput("srl_exec_alu_src",   {29'd0, alu_src},   32'd5);
    checkOutput("srl_exec_alu_op",    {28'd0, alu_op},    32'd13);
    checkOutput("srl_exec_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("srl_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("srl_result",    out_result,         32'h0000_001E);
    tick();
    checkOutput("srl_idle_busy", {31'd0, busy},      32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
